// File: rtl/uart_rx_word_packer_pkg.sv
// Shared types and defaults for the UART receive word packer.
package uart_rx_word_packer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } pack_state_e;

  localparam int unsigned DefDataBits     = 8;
  localparam int unsigned DefWordBytes    = 4;
  localparam int unsigned DefTimeoutTicks = 2048;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter: counts enabled ticks, pulses expire on the final tick.
module uart_rx_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 2048
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_TICKS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A value of zero disables the timeout entirely.
  assign expire = (TIMEOUT_TICKS != 0) && enable && !clear && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs consecutive UART bytes into little-endian words behind a one-word valid/ready buffer.
module uart_rx_word_packer
  import uart_rx_word_packer_pkg::*;
#(
  parameter int unsigned DATA_BITS     = DefDataBits,
  parameter int unsigned WORD_BYTES    = DefWordBytes,
  parameter int unsigned TIMEOUT_TICKS = DefTimeoutTicks
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_tick,
  input  logic                            rx_done_tick,
  input  logic [DATA_BITS-1:0]            rx_data,
  input  logic                            flush,
  input  logic                            word_ready,
  output logic                            word_valid,
  output logic [WORD_BYTES*DATA_BITS-1:0] word_data,
  output logic                            overrun,
  output logic                            timeout_tick
);

  localparam int unsigned WW  = WORD_BYTES * DATA_BITS;
  localparam int unsigned CbW = $clog2(WORD_BYTES);
  localparam logic [CbW-1:0] LastByte = CbW'(WORD_BYTES - 1);

  pack_state_e    state_q, state_d;
  logic [CbW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WW-1:0]  asm_q, asm_d;
  logic [WW-1:0]  shifted;
  logic           word_valid_q, word_valid_d;
  logic [WW-1:0]  word_data_q, word_data_d;
  logic           overrun_q, overrun_d;
  logic           timeout_tick_q, timeout_tick_d;
  logic           to_clear, to_enable, to_expire;

  // New byte enters at the top so the first byte ends up in the LSBs.
  assign shifted = {rx_data, asm_q[WW-1:DATA_BITS]};

  assign to_clear  = flush || rx_done_tick || (state_q == StIdle);
  assign to_enable = s_tick && (state_q == StCollect);

  uart_rx_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (to_clear),
    .enable(to_enable),
    .expire(to_expire)
  );

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    word_valid_d   = word_valid_q;
    word_data_d    = word_data_q;
    overrun_d      = overrun_q;
    timeout_tick_d = 1'b0;

    if (flush) begin
      state_d      = StIdle;
      byte_cnt_d   = '0;
      asm_d        = '0;
      word_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (word_valid_q && word_ready) begin
        word_valid_d = 1'b0;
      end

      if (rx_done_tick) begin
        asm_d = shifted;
        if (byte_cnt_q == LastByte) begin
          state_d    = StIdle;
          byte_cnt_d = '0;
          if (!word_valid_q || word_ready) begin
            word_data_d  = shifted;
            word_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          state_d    = StCollect;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end else if (to_expire) begin
        state_d        = StIdle;
        byte_cnt_d     = '0;
        asm_d          = '0;
        timeout_tick_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      word_valid_q   <= 1'b0;
      word_data_q    <= '0;
      overrun_q      <= 1'b0;
      timeout_tick_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      word_valid_q   <= word_valid_d;
      word_data_q    <= word_data_d;
      overrun_q      <= overrun_d;
      timeout_tick_q <= timeout_tick_d;
    end
  end

  assign word_valid   = word_valid_q;
  assign word_data    = word_data_q;
  assign overrun      = overrun_q;
  assign timeout_tick = timeout_tick_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer with 8-bit bytes, 4-byte words, 16-tick timeout.
module tb_uart_rx_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_tick = 1'b0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [31:0] word_data;
  logic        overrun;
  logic        timeout_tick;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_rx_word_packer #(
    .DATA_BITS    (8),
    .WORD_BYTES   (4),
    .TIMEOUT_TICKS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .flush       (flush),
    .word_ready  (word_ready),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .overrun     (overrun),
    .timeout_tick(timeout_tick)
  );

  // Pulses rx_done_tick for one clock; returns at the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({word_valid, word_data, overrun, timeout_tick} !== 35'd0) begin
      $display("FAIL reset_outputs: got v=%b d=%h o=%b t=%b want all 0",
               word_valid, word_data, overrun, timeout_tick);
    end else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_word();
    word_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    total++;
    if (word_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", word_valid);
    else passed++;
    send_byte(8'h44);
    total++;
    if (word_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", word_valid);
    else passed++;
    total++;
    if (word_data !== 32'h44332211) $display("FAIL basic_data: got %h want 44332211", word_data);
    else passed++;
    @(negedge clk);
    total++;
    if (word_valid !== 1'b0) $display("FAIL basic_drop: got %b want 0", word_valid);
    else passed++;
  endtask

  task automatic test_overrun();
    word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun);
    else passed++;
    total++;
    if (word_valid !== 1'b1 || word_data !== 32'h44332211)
      $display("FAIL ovr_held: got v=%b d=%h want v=1 d=44332211", word_valid, word_data);
    else passed++;
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    total++;
    if (word_valid !== 1'b0) $display("FAIL ovr_single_xfer: got %b want 0", word_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (word_valid !== 1'b0 || word_data === 32'h88776655)
      $display("FAIL ovr_no_dropped: got v=%b d=%h want v=0 d!=88776655", word_valid, word_data);
    else passed++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (overrun !== 1'b0) $display("FAIL ovr_flush_clear: got %b want 0", overrun);
    else passed++;
  endtask

  task automatic test_back_to_back();
    word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = 8'h88;
    word_ready   = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    word_ready   = 1'b0;
    total++;
    if (word_valid !== 1'b1 || word_data !== 32'h88776655)
      $display("FAIL b2b_reload: got v=%b d=%h want v=1 d=88776655", word_valid, word_data);
    else passed++;
    total++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun);
    else passed++;
    word_ready = 1'b1;
    @(negedge clk);
    total++;
    if (word_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", word_valid);
    else passed++;
  endtask

  task automatic test_timeout();
    int pulses = 0;
    word_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (timeout_tick === 1'b1) pulses++;
      s_tick = 1'b1;
      @(negedge clk);
      if (timeout_tick === 1'b1) pulses++;
      s_tick = 1'b0;
    end
    total++;
    if (pulses != 0) $display("FAIL to_early: got %0d pulses want 0", pulses);
    else passed++;
    @(negedge clk);
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
    total++;
    if (timeout_tick !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout_tick);
    else passed++;
    @(negedge clk);
    total++;
    if (timeout_tick !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", timeout_tick);
    else passed++;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    total++;
    if (word_valid !== 1'b0) $display("FAIL to_partial_dropped: got %b want 0", word_valid);
    else passed++;
    send_byte(8'h04);
    total++;
    if (word_valid !== 1'b1 || word_data !== 32'h04030201)
      $display("FAIL to_next_word: got v=%b d=%h want v=1 d=04030201", word_valid, word_data);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_flush();
    word_ready = 1'b1;
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = 8'hD4;
    flush        = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    flush        = 1'b0;
    total++;
    if (word_valid !== 1'b0 || overrun !== 1'b0)
      $display("FAIL flush_beats_byte: got v=%b o=%b want v=0 o=0", word_valid, overrun);
    else passed++;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    total++;
    if (word_valid !== 1'b0) $display("FAIL flush_cnt_cleared: got %b want 0", word_valid);
    else passed++;
    send_byte(8'h08);
    total++;
    if (word_valid !== 1'b1 || word_data !== 32'h08070605)
      $display("FAIL flush_clean_word: got v=%b d=%h want v=1 d=08070605", word_valid, word_data);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    word_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({word_valid, word_data, overrun, timeout_tick} !== 35'd0)
      $display("FAIL async_reset: got v=%b d=%h o=%b t=%b want all 0",
               word_valid, word_data, overrun, timeout_tick);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    word_ready = 1'b1;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    total++;
    if (word_valid !== 1'b0) $display("FAIL rst_partial_gone: got %b want 0", word_valid);
    else passed++;
    send_byte(8'h40);
    total++;
    if (word_valid !== 1'b1 || word_data !== 32'h40302010)
      $display("FAIL rst_next_word: got v=%b d=%h want v=1 d=40302010", word_valid, word_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
